ldm_p2s_stream: RTL and testbench

Parametrised successor of the LDM parallel-to-serial line selector. It captures a full block of LINES×LINE_W pixel data into a shadow/active double buffer. In STREAM mode it serialises the block one line per accepted handshake toward the LDM line consumer. In ADDR mode it keeps legacy random-access line selection. It sits between the pixel gatherer and the LDM line driver.

---
 rtl/ldm_p2s_stream.sv | 152 +++++++++++++++
 tb/tb_ldm_p2s_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_p2s_stream.sv
// ldm_p2s_stream: block capture with a shadow/active double buffer, feeding
// the LDM line driver either by random-access line select (ADDR mode) or as
// a valid/ready stream of one line per handshake (STREAM mode).
module ldm_p2s_stream #(
  parameter int LINE_W = 16,
  parameter int LINES  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MODE,
  input  logic [LINE_W*LINES-1:0]  PIXEL_DATA,
  input  logic                     PIXEL_DATA_EN,
  output logic                     PIXEL_READY,
  input  logic [ADDR_W-1:0]        LDM_ADDR,
  output logic [LINE_W-1:0]        LDM_LINE_DATA,
  output logic                     LDM_LINE_VALID,
  input  logic                     LDM_LINE_READY,
  output logic [ADDR_W-1:0]        LDM_LINE_IDX,
  output logic                     LDM_LINE_LAST,
  output logic                     FRAME_DONE,
  input  logic                     OVF_CLR,
  output logic                     OVERFLOW
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINES - 1);

  logic [LINES-1:0][LINE_W-1:0] r_shadow;
  logic [LINES-1:0][LINE_W-1:0] r_active;
  logic                         r_shadow_full;
  logic                         r_frame_done;
  logic                         r_ovf;
  state_t                       r_state;
  logic [ADDR_W-1:0]            r_idx;

  state_t                       w_state_nxt;
  logic [ADDR_W-1:0]            w_idx_nxt;
  logic                         w_shadow_full_nxt;
  logic                         w_reload;
  logic                         w_done_nxt;
  logic                         w_accept;
  logic                         w_valid;
  logic                         w_hs;
  logic [ADDR_W-1:0]            w_rd_idx;
  logic [LINE_W-1:0]            w_rd_data;

  // ADDR mode always takes a block; STREAM mode only while the shadow is free.
  assign PIXEL_READY = MODE ? ~r_shadow_full : 1'b1;
  assign w_accept    = PIXEL_DATA_EN & PIXEL_READY;
  // Leaving STREAM mode kills VALID immediately, before the FSM drops to IDLE.
  assign w_valid     = MODE & (r_state == S_STREAM);
  assign w_hs        = w_valid & LDM_LINE_READY;

  // Next-state logic: idle->stream transfer, per-line advance, zero-bubble reload.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_shadow_full_nxt = r_shadow_full;
    w_reload          = 1'b0;
    w_done_nxt        = 1'b0;
    if (!MODE) begin
      // Random-access mode: stream machinery parked, any pending block dropped.
      w_state_nxt       = S_IDLE;
      w_idx_nxt         = '0;
      w_shadow_full_nxt = 1'b0;
    end else begin
      // Accept is impossible while the shadow is full, so it never collides
      // with the shadow being drained into the active buffer below.
      if (w_accept) w_shadow_full_nxt = 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_shadow_full) begin
            w_reload          = 1'b1;
            w_shadow_full_nxt = 1'b0;
            w_idx_nxt         = '0;
            w_state_nxt       = S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (r_idx != LAST_IDX) begin
              w_idx_nxt = r_idx + ADDR_W'(1);
            end else begin
              w_done_nxt = 1'b1;
              w_idx_nxt  = '0;
              if (r_shadow_full) begin
                w_reload          = 1'b1;
                w_shadow_full_nxt = 1'b0;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state, line index, shadow occupancy and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_shadow_full <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_shadow_full <= w_shadow_full_nxt;
      r_frame_done  <= w_done_nxt;
    end
  end

  // Block buffers: STREAM loads the shadow, ADDR writes active directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (MODE && w_accept) r_shadow <= PIXEL_DATA;
      if (!MODE && w_accept) r_active <= PIXEL_DATA;
      else if (w_reload)     r_active <= r_shadow;
    end
  end

  // Sticky overflow on a dropped load request; a new drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst)                               r_ovf <= 1'b0;
    else if (PIXEL_DATA_EN && !PIXEL_READY) r_ovf <= 1'b1;
    else if (OVF_CLR)                      r_ovf <= 1'b0;
  end

  // Line read mux; an index with no matching line (ADDR >= LINES) reads 0.
  always_comb begin
    w_rd_idx  = MODE ? r_idx : LDM_ADDR;
    w_rd_data = '0;
    for (int i = 0; i < LINES; i++) begin
      if (w_rd_idx == ADDR_W'(i)) w_rd_data = r_active[i];
    end
  end

  assign LDM_LINE_DATA  = (MODE && !w_valid) ? '0 : w_rd_data;
  assign LDM_LINE_VALID = w_valid;
  assign LDM_LINE_IDX   = w_valid ? r_idx : '0;
  assign LDM_LINE_LAST  = w_valid & (r_idx == LAST_IDX);
  assign FRAME_DONE     = r_frame_done;
  assign OVERFLOW       = r_ovf;

endmodule

// File: tb/tb_ldm_p2s_stream.sv
// Bench for ldm_p2s_stream: table-driven ADDR reads, directed stream corner
// cases, and randomized traffic compared against a line-queue model.
module tb_ldm_p2s_stream;
  localparam int LINE_W = 16;
  localparam int LINES  = 16;
  localparam int ADDR_W = 4;
  localparam int BW     = LINE_W * LINES;

  logic              clk = 1'b0;
  logic              rst, MODE, PIXEL_DATA_EN, PIXEL_READY;
  logic [BW-1:0]     PIXEL_DATA;
  logic [ADDR_W-1:0] LDM_ADDR, LDM_LINE_IDX;
  logic [LINE_W-1:0] LDM_LINE_DATA;
  logic              LDM_LINE_VALID, LDM_LINE_READY, LDM_LINE_LAST;
  logic              FRAME_DONE, OVF_CLR, OVERFLOW;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ldm_p2s_stream #(.LINE_W(LINE_W), .LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .MODE(MODE),
    .PIXEL_DATA(PIXEL_DATA), .PIXEL_DATA_EN(PIXEL_DATA_EN), .PIXEL_READY(PIXEL_READY),
    .LDM_ADDR(LDM_ADDR), .LDM_LINE_DATA(LDM_LINE_DATA), .LDM_LINE_VALID(LDM_LINE_VALID),
    .LDM_LINE_READY(LDM_LINE_READY), .LDM_LINE_IDX(LDM_LINE_IDX), .LDM_LINE_LAST(LDM_LINE_LAST),
    .FRAME_DONE(FRAME_DONE), .OVF_CLR(OVF_CLR), .OVERFLOW(OVERFLOW)
  );

  // Reference model: the stream is a queue of line numbers still to deliver.
  logic [LINE_W-1:0] m_active [LINES];
  logic [LINE_W-1:0] m_pend   [LINES];
  logic              m_pf, m_done, m_ovf;
  int                m_q[$];
  bit                chk_en = 1'b0;

  function automatic logic [BW-1:0] mk_block(input logic [LINE_W-1:0] base);
    logic [BW-1:0] b;
    for (int i = 0; i < LINES; i++) b[i*LINE_W +: LINE_W] = base + LINE_W'(i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic              v;
    int                ix;
    logic [LINE_W-1:0] d;
    v  = MODE && (m_q.size() > 0);
    ix = v ? m_q[0] : 0;
    if (MODE) d = v ? m_active[ix] : '0;
    else      d = (int'(LDM_ADDR) < LINES) ? m_active[LDM_ADDR] : '0;
    chk("m_data",  32'(LDM_LINE_DATA),  32'(d));
    chk("m_valid", 32'(LDM_LINE_VALID), 32'(v));
    chk("m_idx",   32'(LDM_LINE_IDX),   32'(ix));
    chk("m_last",  32'(LDM_LINE_LAST),  32'(v && ix == LINES-1));
    chk("m_ready", 32'(PIXEL_READY),    32'(MODE ? !m_pf : 1'b1));
    chk("m_done",  32'(FRAME_DONE),     32'(m_done));
    chk("m_ovf",   32'(OVERFLOW),       32'(m_ovf));
  endtask

  task automatic model_update();
    logic rdy, v, old_pf;
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin m_active[i] = '0; m_pend[i] = '0; end
      m_pf = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_q.delete();
      return;
    end
    rdy = MODE ? !m_pf : 1'b1;
    v   = MODE && (m_q.size() > 0);
    if (PIXEL_DATA_EN && !rdy) m_ovf = 1'b1;
    else if (OVF_CLR)          m_ovf = 1'b0;
    m_done = 1'b0;
    if (!MODE) begin
      m_q.delete();
      m_pf = 1'b0;
      if (PIXEL_DATA_EN)
        for (int i = 0; i < LINES; i++) m_active[i] = PIXEL_DATA[i*LINE_W +: LINE_W];
    end else begin
      old_pf = m_pf;
      if (v && LDM_LINE_READY) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
      if (m_q.size() == 0 && old_pf) begin
        for (int i = 0; i < LINES; i++) begin m_active[i] = m_pend[i]; m_q.push_back(i); end
        m_pf = 1'b0;
      end
      if (PIXEL_DATA_EN && rdy) begin
        for (int i = 0; i < LINES; i++) m_pend[i] = PIXEL_DATA[i*LINE_W +: LINE_W];
        m_pf = 1'b1;
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later.
  task automatic step();
    #1;
    if (chk_en) model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic load(input logic [LINE_W-1:0] base);
    PIXEL_DATA = mk_block(base); PIXEL_DATA_EN = 1'b1; step(); PIXEL_DATA_EN = 1'b0;
  endtask

  // One block through STREAM mode, optionally stalling hlen cycles at line hidx.
  task automatic run_stream(input int hidx, input int hlen, input logic [LINE_W-1:0] base);
    logic [LINE_W-1:0] got[$];
    int h = 0;
    int cyc = 0;
    MODE = 1'b1; LDM_LINE_READY = 1'b1;
    load(base);
    #1;
    chk("lat_n1_valid", 32'(LDM_LINE_VALID), 0);
    chk("lat_n1_pready", 32'(PIXEL_READY), 0);
    step();
    #1;
    chk("lat_n2_valid", 32'(LDM_LINE_VALID), 1);
    chk("lat_n2_idx", 32'(LDM_LINE_IDX), 0);
    chk("lat_n2_data", 32'(LDM_LINE_DATA), 32'(base));
    while (got.size() < LINES && cyc < 200) begin
      LDM_LINE_READY = !(LDM_LINE_VALID && int'(LDM_LINE_IDX) == hidx && h < hlen);
      if (!LDM_LINE_READY) begin
        h++;
        chk("hold_data", 32'(LDM_LINE_DATA), 32'(base + LINE_W'(hidx)));
      end
      if (LDM_LINE_VALID && LDM_LINE_READY) begin
        got.push_back(LDM_LINE_DATA);
        chk("stream_last", 32'(LDM_LINE_LAST), 32'(got.size() == LINES));
      end
      step(); cyc++;
    end
    LDM_LINE_READY = 1'b1;
    chk("stream_count", 32'(got.size()), LINES);
    chk("hold_cycles", 32'(h), 32'(hlen));
    for (int i = 0; i < got.size(); i++) chk("stream_seq", 32'(got[i]), 32'(base + LINE_W'(i)));
    #1;
    chk("done_pulse", 32'(FRAME_DONE), 1);
    chk("idle_valid", 32'(LDM_LINE_VALID), 0);
    step();
    #1;
    chk("done_clear", 32'(FRAME_DONE), 0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] exp;
  } avec_t;
  avec_t tbl[6];

  initial begin
    logic [LINE_W-1:0] got[$];
    int c, gaps;

    tbl[0] = '{4'd5,  16'hA005};
    tbl[1] = '{4'd15, 16'hA00F};
    tbl[2] = '{4'd0,  16'hA000};
    tbl[3] = '{4'd9,  16'hA009};
    tbl[4] = '{4'd1,  16'hA001};
    tbl[5] = '{4'd14, 16'hA00E};

    rst = 1'b1; MODE = 1'b0; PIXEL_DATA = '0; PIXEL_DATA_EN = 1'b0;
    LDM_ADDR = '0; LDM_LINE_READY = 1'b0; OVF_CLR = 1'b0;
    @(negedge clk);
    step();
    chk_en = 1'b1; rst = 1'b0;
    #1;
    chk("rst_data", 32'(LDM_LINE_DATA), 0);
    chk("rst_valid", 32'(LDM_LINE_VALID), 0);
    chk("rst_last", 32'(LDM_LINE_LAST), 0);
    chk("rst_idx", 32'(LDM_LINE_IDX), 0);
    chk("rst_pready", 32'(PIXEL_READY), 1);
    chk("rst_done", 32'(FRAME_DONE), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);

    // ADDR mode: write visible the cycle after the load.
    LDM_ADDR = 4'd5;
    #1 chk("addr_pre_load", 32'(LDM_LINE_DATA), 0);
    load(16'hA000);
    for (int i = 0; i < 6; i++) begin
      LDM_ADDR = tbl[i].addr;
      #1 chk("addr_tbl", 32'(LDM_LINE_DATA), 32'(tbl[i].exp));
      chk("addr_valid", 32'(LDM_LINE_VALID), 0);
      step();
    end

    // STREAM without and with backpressure.
    do_reset();
    run_stream(0, 0, 16'hA000);
    do_reset();
    run_stream(3, 4, 16'hA000);

    // Back-to-back blocks with overflow on the full shadow.
    do_reset();
    MODE = 1'b1; LDM_LINE_READY = 1'b1;
    load(16'hA000); step();
    got.delete(); c = 0; gaps = 0;
    while (got.size() < 2*LINES && c < 200) begin
      PIXEL_DATA_EN = (c < 3);
      OVF_CLR = (c == 2 || c == 3);
      PIXEL_DATA = mk_block(c == 0 ? 16'hB000 : 16'hC000);
      #1;
      if (c == 0)  chk("b2b_pready0", 32'(PIXEL_READY), 1);
      if (c == 1)  chk("b2b_pready1", 32'(PIXEL_READY), 0);
      if (c == 2)  chk("ovf_set", 32'(OVERFLOW), 1);
      if (c == 3)  chk("ovf_set_wins", 32'(OVERFLOW), 1);
      if (c == 4)  chk("ovf_clr", 32'(OVERFLOW), 0);
      if (c == 15) chk("b2b_pready15", 32'(PIXEL_READY), 0);
      if (c == 16) begin
        chk("b2b_pready16", 32'(PIXEL_READY), 1);
        chk("b2b_first_b", 32'(LDM_LINE_DATA), 32'h0000B000);
        chk("b2b_done_mid", 32'(FRAME_DONE), 1);
      end
      if (!LDM_LINE_VALID) gaps++;
      else got.push_back(LDM_LINE_DATA);
      step(); c++;
    end
    PIXEL_DATA_EN = 1'b0; OVF_CLR = 1'b0;
    chk("b2b_gaps", 32'(gaps), 0);
    chk("b2b_count", 32'(got.size()), 32'(2*LINES));
    for (int i = 0; i < got.size(); i++)
      chk("b2b_seq", 32'(got[i]), 32'(i < LINES ? 16'hA000 + i : 16'hB000 + i - LINES));
    #1 chk("b2b_done_end", 32'(FRAME_DONE), 1);
    step();

    // Mode abort at line 7; active buffer stays readable in ADDR mode.
    do_reset();
    MODE = 1'b1; LDM_LINE_READY = 1'b1;
    load(16'hA000); step();
    c = 0;
    while (!(LDM_LINE_VALID && LDM_LINE_IDX == 4'd7) && c < 50) begin step(); c++; end
    chk("abort_reach7", 32'(LDM_LINE_IDX), 7);
    MODE = 1'b0; LDM_ADDR = 4'd7;
    #1 chk("abort_valid0", 32'(LDM_LINE_VALID), 0);
    chk("abort_addr_data", 32'(LDM_LINE_DATA), 32'h0000A007);
    step();
    #1 chk("abort_valid1", 32'(LDM_LINE_VALID), 0);
    chk("abort_done1", 32'(FRAME_DONE), 0);
    step();
    MODE = 1'b1;
    step(); step();
    #1 chk("abort_resume_valid", 32'(LDM_LINE_VALID), 0);
    chk("abort_resume_pready", 32'(PIXEL_READY), 1);

    // Reset mid-stream with a pending block and overflow set.
    do_reset();
    MODE = 1'b1; LDM_LINE_READY = 1'b1;
    load(16'hA000); step();
    PIXEL_DATA = mk_block(16'hB000); PIXEL_DATA_EN = 1'b1; step();
    PIXEL_DATA = mk_block(16'hC000); step();
    PIXEL_DATA_EN = 1'b0;
    #1 chk("mid_ovf", 32'(OVERFLOW), 1);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    chk("mrst_data", 32'(LDM_LINE_DATA), 0);
    chk("mrst_valid", 32'(LDM_LINE_VALID), 0);
    chk("mrst_idx", 32'(LDM_LINE_IDX), 0);
    chk("mrst_pready", 32'(PIXEL_READY), 1);
    chk("mrst_ovf", 32'(OVERFLOW), 0);
    chk("mrst_done", 32'(FRAME_DONE), 0);
    step(); step(); step();
    #1 chk("mrst_no_stream", 32'(LDM_LINE_VALID), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 255) == 0);
      MODE = ($urandom_range(0, 31) != 0);
      PIXEL_DATA_EN = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < BW/32; w++) PIXEL_DATA[w*32 +: 32] = $urandom;
      LDM_ADDR = ADDR_W'($urandom);
      LDM_LINE_READY = ($urandom_range(0, 3) != 0);
      OVF_CLR = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
